// File: rtl/simon_pkg.sv
// Shared constants, types and round helpers for the Simon 32/64 decryptor.
package simon_pkg;

  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  localparam word_t KEY_CONST = 16'hFFFC;

  // Bit n holds z0[n]: the sequence 1111101000... read from bit 0 upward.
  localparam logic [61:0] Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DECRYPT,
    ST_DONE
  } fsm_e;

  function automatic word_t ror1(input word_t v);
    return {v[0], v[15:1]};
  endfunction

  function automatic word_t ror3(input word_t v);
    return {v[2:0], v[15:3]};
  endfunction

  // Round function f(v) = (rol1 v & rol8 v) ^ rol2 v.
  function automatic word_t simon_f(input word_t v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  function automatic word_t key_mix(input word_t hi, input word_t lo);
    word_t t;
    t = ror3(hi) ^ lo;
    return t ^ ror1(t);
  endfunction

endpackage

// File: rtl/simon_decrypt_if.sv
// Nibble-serial load/unload and status bundle of the Simon decryptor.
interface simon_decrypt_if;
  logic       i_shift;
  logic [3:0] i_data;
  logic [3:0] o_data;
  logic       o_busy;
  logic       o_done;

  modport slave (
    input  i_shift,
    input  i_data,
    output o_data,
    output o_busy,
    output o_done
  );

  modport master (
    output i_shift,
    output i_data,
    input  o_data,
    input  o_busy,
    input  o_done
  );
endinterface

// File: rtl/simon_key_step.sv
// One Simon 32/64 key-schedule step on a four-word window, forward or inverse.
module simon_key_step
  import simon_pkg::*;
(
  input  logic [63:0] win_i,
  input  logic        inverse_i,
  input  logic        z_i,
  output logic [63:0] win_o
);

  word_t tmp_fwd;
  word_t tmp_inv;
  word_t top_new;
  word_t bot_new;

  always_comb begin
    tmp_fwd = key_mix(win_i[63:48], win_i[31:16]);
    tmp_inv = key_mix(win_i[47:32], win_i[15:0]);
    top_new = KEY_CONST ^ {15'd0, z_i} ^ win_i[15:0] ^ tmp_fwd;
    // Inverse solves the forward equation for the word that fell off the bottom.
    bot_new = KEY_CONST ^ {15'd0, z_i} ^ win_i[63:48] ^ tmp_inv;
    win_o   = inverse_i ? {win_i[47:0], bot_new} : {top_new, win_i[63:16]};
  end

endmodule

// File: rtl/simon_decrypt.sv
// Simon 32/64 nibble-serial block decryptor; key is restored after each block.
// Define SIMON_DEC_ABORT_EN to let i_shift abort a running decryption.
module simon_decrypt
  import simon_pkg::*;
#(
  parameter int NUM_ROUNDS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  simon_decrypt_if.slave  bus
);

  localparam int CW = $clog2(NUM_ROUNDS);
  localparam logic [CW-1:0] EXP_LAST = CW'(NUM_ROUNDS - 5);
  localparam logic [CW-1:0] REV_LAST = CW'(NUM_ROUNDS - 5);
  localparam logic [CW-1:0] DEC_LAST = CW'(NUM_ROUNDS - 1);

  fsm_e          fsm_q, fsm_d;
  logic [63:0]   key_q, key_d;
  logic [31:0]   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          busy;
  logic          shift_en;
  logic          inverse;
  logic [5:0]    z_idx;
  logic [63:0]   step_win;

  assign busy    = (fsm_q == ST_EXPAND) || (fsm_q == ST_DECRYPT);
  assign inverse = (fsm_q == ST_DECRYPT);

`ifdef SIMON_DEC_ABORT_EN
  assign shift_en = bus.i_shift;
`else
  assign shift_en = bus.i_shift & ~busy;
`endif

  // Decryption walks z0 backwards from the last index used by the expansion.
  assign z_idx = inverse ? (6'(NUM_ROUNDS - 5) - 6'(cnt_q)) : 6'(cnt_q);

  simon_key_step u_key_step (
    .win_i     (key_q),
    .inverse_i (inverse),
    .z_i       (Z0[z_idx]),
    .win_o     (step_win)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q   <= ST_IDLE;
      key_q   <= '0;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      key_q   <= key_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    state_d = state_q;
    if (shift_en) begin
      fsm_d   = ST_LOAD;
      key_d   = {bus.i_data, key_q[63:4]};
      state_d = {key_q[3:0], state_q[31:4]};
    end else begin
      unique case (fsm_q)
        ST_LOAD: begin
          fsm_d = ST_EXPAND;
          cnt_d = '0;
        end
        ST_EXPAND: begin
          key_d = step_win;
          if (cnt_q == EXP_LAST) begin
            fsm_d = ST_DECRYPT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DECRYPT: begin
          state_d = {state_q[15:0],
                     state_q[31:16] ^ simon_f(state_q[15:0]) ^ key_q[63:48]};
          // Once k0..k3 are back in the window, rotate so they end in place.
          key_d   = (cnt_q <= REV_LAST) ? step_win : {key_q[47:0], key_q[63:48]};
          if (cnt_q == DEC_LAST) begin
            fsm_d = ST_DONE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_data = state_q[3:0];
    bus.o_busy = busy;
    bus.o_done = (fsm_q == ST_DONE);
  end

endmodule

// File: tb/tb_simon_decrypt.sv
// Directed and round-trip bench for simon_decrypt (32 rounds).
module tb_simon_decrypt;

  localparam logic [31:0] KA_CT  = 32'hc69be9bb;
  localparam logic [31:0] KA_PT  = 32'h65656877;
  localparam logic [63:0] KA_KEY = 64'h1918111009080100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Index 0 is the leftmost character of the z0 sequence.
  logic [0:61] z0_seq = 62'b11111010001001010110000111001101111101000100101011000011100110;

  simon_decrypt_if bus();

  simon_decrypt #(.NUM_ROUNDS(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encrypt(input logic [31:0] pt, input logic [63:0] key);
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      t = {k[i+3][2:0], k[i+3][15:3]} ^ k[i+1];
      t = t ^ {t[0], t[15:1]};
      k[i+4] = 16'hfffc ^ {15'd0, z0_seq[i]} ^ k[i] ^ t;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]}) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift in a job; returns what came out (previous plaintext, then previous key).
  task automatic load_job(input logic [31:0] ct, input logic [63:0] key,
                          output logic [31:0] prev_pt, output logic [63:0] prev_key);
    for (int i = 0; i < 24; i++) begin
      if (i < 8) prev_pt[4*i +: 4] = bus.o_data;
      else       prev_key[4*(i-8) +: 4] = bus.o_data;
      bus.i_shift = 1'b1;
      bus.i_data  = (i < 8) ? ct[4*i +: 4] : key[4*(i-8) +: 4];
      tick();
    end
    bus.i_shift = 1'b0;
    bus.i_data  = 4'h0;
  endtask

  task automatic wait_done(input int max_edges, output int edges);
    edges = 0;
    while (bus.o_done !== 1'b1 && edges < max_edges) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.o_data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h want=0", bus.o_data); end
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.o_busy); end
    checks++;
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.o_done); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (bus.o_data !== 4'h0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
        errors++; bad++;
        $display("FAIL idle_after_reset cyc=%0d got data=%h busy=%b done=%b want 0/0/0",
                 i, bus.o_data, bus.o_busy, bus.o_done);
      end
    end
    $display("[reset] outputs zero, 100 idle cycles, %0d deviations", bad);
  endtask

  task automatic test_known_answer();
    logic [31:0] pt;
    logic [63:0] key;
    int e;
    load_job(KA_CT, KA_KEY, pt, key);
    tick();
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL ka_busy got=%b want=1", bus.o_busy); end
    wait_done(100, e);
    checks++;
    if (e + 1 != 61) begin errors++; $display("FAIL ka_latency got=%0d want=61", e + 1); end
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL ka_done_flags got done=%b busy=%b want 1/0", bus.o_done, bus.o_busy);
    end
    $display("[known_answer] ct=%h key=%h latency=%0d", KA_CT, KA_KEY, e + 1);
  endtask

  task automatic test_key_retention();
    logic [31:0] pt;
    logic [63:0] key;
    int e;
    load_job(KA_CT, KA_KEY, pt, key);
    checks++;
    if (pt !== KA_PT) begin errors++; $display("FAIL ka_plaintext got=%h want=%h", pt, KA_PT); end
    checks++;
    if (key !== KA_KEY) begin errors++; $display("FAIL key_restored got=%h want=%h", key, KA_KEY); end
    wait_done(100, e);
    checks++;
    if (e != 61 || bus.o_done !== 1'b1) begin
      errors++; $display("FAIL retention_latency got=%0d done=%b want 61/1", e, bus.o_done);
    end
    $display("[key_retention] unloaded pt=%h key=%h, rerun latency=%0d", pt, key, e);
  endtask

  task automatic test_idle_stability();
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (bus.o_data !== 4'h7 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
        errors++; bad++;
        $display("FAIL idle_in_done cyc=%0d got data=%h done=%b busy=%b want 7/1/0",
                 i, bus.o_data, bus.o_done, bus.o_busy);
      end
    end
    $display("[idle_stability] 100 cycles in DONE, %0d deviations", bad);
  endtask

  task automatic test_reset_mid_decrypt();
    logic [31:0] pt;
    logic [63:0] key;
    load_job(KA_CT, KA_KEY, pt, key);
    checks++;
    if (pt !== KA_PT) begin errors++; $display("FAIL second_plaintext got=%h want=%h", pt, KA_PT); end
    repeat (39) tick();
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", bus.o_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_data !== 4'h0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got data=%h busy=%b done=%b want 0/0/0",
               bus.o_data, bus.o_busy, bus.o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got busy=%b done=%b want 0/0", bus.o_busy, bus.o_done);
    end
    $display("[reset_mid_decrypt] reset at DECRYPT cnt=10");
  endtask

  task automatic test_abort();
    logic [31:0] pt;
    logic [63:0] key;
    int e;
    load_job(KA_CT, KA_KEY, pt, key);
    checks++;
    if (pt !== 32'h0 || key !== 64'h0) begin
      errors++; $display("FAIL unload_after_reset got pt=%h key=%h want 0/0", pt, key);
    end
    repeat (6) tick();
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got=%b want=1", bus.o_busy); end
    bus.i_shift = 1'b1;
    bus.i_data  = 4'h0;
    tick();
    bus.i_shift = 1'b0;
`ifdef SIMON_DEC_ABORT_EN
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", bus.o_busy); end
    wait_done(100, e);
    checks++;
    if (e != 61) begin errors++; $display("FAIL abort_restart_latency got=%0d want=61", e); end
    $display("[abort] enabled, restart latency=%0d", e);
`else
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL ignored_busy got=%b want=1", bus.o_busy); end
    wait_done(100, e);
    checks++;
    if (e + 7 != 61) begin errors++; $display("FAIL ignored_latency got=%0d want=61", e + 7); end
    $display("[abort] disabled, shift ignored, latency=%0d", e + 7);
`endif
  endtask

  task automatic test_round_trip();
    logic [31:0] pt, ct, got_pt, exp_pt;
    logic [63:0] key, got_key, exp_key;
    int e;
    exp_pt  = '0;
    exp_key = '0;
    for (int i = 0; i <= 200; i++) begin
      if (i < 200) begin
        key = {$urandom, $urandom};
        pt  = $urandom;
        ct  = encrypt(pt, key);
      end else begin
        key = '0;
        pt  = '0;
        ct  = '0;
      end
      load_job(ct, key, got_pt, got_key);
      if (i > 0) begin
        checks++;
        if (got_pt !== exp_pt) begin
          errors++; $display("FAIL rt_plaintext n=%0d got=%h want=%h", i - 1, got_pt, exp_pt);
        end
        checks++;
        if (got_key !== exp_key) begin
          errors++; $display("FAIL rt_key n=%0d got=%h want=%h", i - 1, got_key, exp_key);
        end
        $display("[round_trip %0d] key=%h pt=%h out=%h", i - 1, exp_key, exp_pt, got_pt);
      end
      if (i < 200) begin
        wait_done(100, e);
        checks++;
        if (e != 61 || bus.o_done !== 1'b1) begin
          errors++; $display("FAIL rt_latency n=%0d got=%0d done=%b want 61/1", i, e, bus.o_done);
        end
      end
      exp_pt  = pt;
      exp_key = key;
    end
  endtask

  initial begin
    bus.i_shift = 1'b0;
    bus.i_data  = 4'h0;
    test_reset();
    test_known_answer();
    test_key_retention();
    test_idle_stability();
    test_reset_mid_decrypt();
    test_abort();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_decrypt.md
Name: simon_decrypt

Overview:
- Simon 32/64 block decryptor; inverse of the team's free-running Simon encrypt core.
- Same nibble-serial load/unload chain: i_data → key → state → o_data.
- Loads the master key and ciphertext, expands the key schedule forward to the last round keys, then runs the rounds in reverse while walking the key schedule backwards.
- Stops in DONE with plaintext held and the master key restored, so it can decrypt again without a key reload.

Parameters:
- NUM_ROUNDS, 32, cipher rounds; legal range 5..32; 32 is Simon32/64.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_shift  in  1  high: shift one nibble through the load/unload chain this cycle.
- i_data  in  4  nibble shifted in.
- o_data  out  4  state[3:0], the next nibble out.
- o_busy  out  1  high in EXPAND or DECRYPT.
- o_done  out  1  high in DONE.

Behaviour:
- Reset: state IDLE; key[63:0]=0; state[31:0]=0; cnt=0; o_data=0; o_busy=0; o_done=0.
- Register layout:
  - state[31:16]=x, state[15:0]=y.
  - key window: [15:0]=k(i), [31:16]=k(i+1), [47:32]=k(i+2), [63:48]=k(i+3).
- Shift (any edge with i_shift=1, subject to the Optional Feature):
  - key <= {i_data, key[63:4]}; state <= {key[3:0], state[31:4]}; FSM → LOAD.
  - Load order: 8 ciphertext nibbles (y LSN first, then x), then 16 key nibbles (k0 LSN first).
  - Unload: plaintext appears on o_data LSN-first while the next job is shifted in.
- FSM states:
  - IDLE: hold.
  - LOAD, i_shift=0 → EXPAND, cnt=0; no datapath change.
  - EXPAND (cnt 0..NUM_ROUNDS-5), forward key step each edge:
    - tmp = ror3(k(i+3)) ^ k(i+1); tmp ^= ror1(tmp).
    - new top = 16'hFFFC ^ z0[cnt] ^ k(i) ^ tmp; lower words shift down one slot.
    - After the last step → DECRYPT, cnt=0.
  - DECRYPT (j = cnt, 0..NUM_ROUNDS-1), using key word kr = key[63:48]:
    - f(v) = (rol1 v & rol8 v) ^ rol2 v.
    - state <= {y, x ^ f(y) ^ kr}.
    - Key window, j < NUM_ROUNDS-4: reverse step. Words shift up one slot; new [15:0] = 16'hFFFC ^ z0[NUM_ROUNDS-5-j] ^ old[63:48] ^ tmp, with tmp computed from old[47:32] (ror3) and old[15:0].
    - Key window, j ≥ NUM_ROUNDS-4: rotate up (new[15:0]=old[63:48]); the window ends holding k0..k3 in the original slots.
    - j = NUM_ROUNDS-1 → DONE.
  - DONE: hold; i_shift=1 unloads and reloads.
- Latency: o_done rises on the (2·NUM_ROUNDS−3)th edge after the last shift edge (61 for 32 rounds).
- Edge cases:
  - i_shift low in IDLE or DONE: no effect.
  - Asynchronous reset mid-operation returns to the reset values immediately.

Optional Feature:
- Macro SIMON_DEC_ABORT_EN.
- Defined: i_shift=1 in EXPAND or DECRYPT aborts. A shift is performed and the FSM → LOAD; o_busy drops the next cycle.
- Undefined: i_shift is ignored while o_busy=1 (no shift, no state change).

Decomposition:
- Package simon_pkg:
  - Z0: 62-bit constant, bit n = z0[n] = character n of 11111010001001010110000111001101111101000100101011000011100110.
  - KEY_CONST = 16'hFFFC.
  - Word width 16 and state enum.
- Sub-module simon_key_step: purely combinational, forward or inverse key-schedule step selected by one input. Shared by EXPAND and DECRYPT.

Test Plan:
- Known answer: shift B,B,9,E,B,9,6,C then 0,0,1,0,8,0,9,0,0,1,1,1,8,1,9,1; drop i_shift → o_busy high; o_done on edge 61.
  - Unload yields 7,7,8,6,5,6,5,6 (plaintext x=6565, y=6877).
- Key retention: after DONE, shift 8 nibbles of ciphertext c69be9bb, then 16 nibbles reproducing the key → same plaintext. Also confirm key[63:0]=1918111009080100 in DONE.
- Reset mid-DECRYPT (cnt=10): assert i_rst_n=0 → all outputs 0, FSM IDLE, without waiting for a clock.
- Abort: i_shift=1 at EXPAND cnt=5.
  - With SIMON_DEC_ABORT_EN: shift occurs, o_busy=0 next cycle.
  - Without: ignored, done still at edge 61.
- Idle stability: i_shift=0 for 100 cycles from reset or DONE → o_data, o_done unchanged.
- Round-trip: 200 random key/plaintext pairs through the encrypt core (capture after 32 rounds) then this block → plaintext matches.
